// File: rtl/fetch_pc_queue.sv
// Fetch front end: owns the fetch PC, issues in-order I-side requests under a credit limit,
// and queues responses (or a misaligned-fetch marker) with their PCs for decode.
module fetch_pc_queue #(
  parameter logic [31:0] RESET_PC    = 32'hbfc00000,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned PC_STEP     = 4
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        exc_redirect,
  input  logic [31:0] exc_pc,
  input  logic        br_redirect,
  input  logic [31:0] br_pc,
  output logic        req_valid,
  output logic [31:0] req_addr,
  input  logic        req_ready,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_adel,
  input  logic        out_ready
);

  localparam int unsigned AW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_WIDE = (CW + 1)'(QUEUE_DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT  = CW'(QUEUE_DEPTH);

  logic [31:0]            fetch_pc;
  logic                   halted;
  logic [CW-1:0]          count, inflight, discard;
  logic [AW-1:0]          q_rd, q_wr, p_rd, p_wr;
  logic [31:0]            q_pc    [QUEUE_DEPTH];
  logic [31:0]            q_instr [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] q_adel;
  logic [31:0]            p_pc    [QUEUE_DEPTH];

  logic          accept, resp_take, resp_push, adel_push, push, pop, redirect;
  logic [31:0]   redirect_pc;
  logic [CW:0]   used;
  logic [CW-1:0] inflight_nxt;

  always_comb begin
    used         = {1'b0, count} + {1'b0, inflight};
    req_valid    = !halted && (fetch_pc[1:0] == 2'b00) && (used < DEPTH_WIDE);
    req_addr     = fetch_pc;
    accept       = req_valid && req_ready;
    resp_take    = resp_valid && (inflight != '0);
    resp_push    = resp_take && (discard == '0);
    // Marker waits for inflight to drain, so it never collides with a response push.
    adel_push    = !halted && (fetch_pc[1:0] != 2'b00) && (inflight == '0) && (count < DEPTH_CNT);
    push         = resp_push || adel_push;
    out_valid    = (count != '0);
    pop          = out_valid && out_ready;
    redirect     = exc_redirect || br_redirect;
    redirect_pc  = exc_redirect ? exc_pc : br_pc;
    inflight_nxt = inflight + CW'(accept) - CW'(resp_take);
    out_pc       = out_valid ? q_pc[q_rd]    : '0;
    out_instr    = out_valid ? q_instr[q_rd] : '0;
    out_adel     = out_valid ? q_adel[q_rd]  : 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      fetch_pc <= RESET_PC;
      halted   <= 1'b0;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
      q_rd     <= '0;
      q_wr     <= '0;
      p_rd     <= '0;
      p_wr     <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (accept) begin
        p_pc[p_wr] <= fetch_pc;
        p_wr       <= p_wr + 1'b1;
      end
      if (resp_take) p_rd <= p_rd + 1'b1;

      if (redirect) begin
        fetch_pc <= redirect_pc;
        halted   <= 1'b0;
        count    <= '0;
        q_rd     <= '0;
        q_wr     <= '0;
        // Everything still outstanding after this cycle, older discards included, is dropped.
        discard  <= inflight_nxt;
      end else begin
        if (accept)    fetch_pc <= fetch_pc + 32'(PC_STEP);
        if (adel_push) halted   <= 1'b1;
        if (resp_take && (discard != '0)) discard <= discard - 1'b1;
        if (push) begin
          q_pc[q_wr]    <= adel_push ? fetch_pc : p_pc[p_rd];
          q_instr[q_wr] <= adel_push ? 32'h0 : resp_data;
          q_adel[q_wr]  <= adel_push;
          q_wr          <= q_wr + 1'b1;
        end
        if (pop) q_rd <= q_rd + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule
